// File: rtl/i2c_target_rx.sv
// I2C write-only target: oversampled SCL/SDA, START/STOP detect, 7-bit address match, ACK drive, byte strobes.
// Latency: rx_valid rises 2 clk after the synchronized 8th SCL rise of a data byte is first seen.
// Backpressure: none; every matched data byte is ACKed. Define I2C_TARGET_GCALL_EN to also accept general call (7'h00, W).
module i2c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       busy,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_seen;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       first_q, first_d;
    logic       pend_q, pend_d;
    logic       pend_first_q, pend_first_d;
    logic       stop_det_q, stop_det_d;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, rx_first_q;

    logic [7:0] byte_nx;
    logic       addr_ok;

    // Synchronize pad inputs and keep one history flop; reset to the idle-bus level so no false edges appear.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_seen = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign byte_nx   = {shift_q[6:0], sda_s};

    // Address acceptance: write to our address (and general call when enabled).
    always_comb begin
`ifdef I2C_TARGET_GCALL_EN
        addr_ok = ~byte_nx[0] & ((byte_nx[7:1] == TARGET_ADDR) | (byte_nx[7:1] == 7'h00));
`else
        addr_ok = ~byte_nx[0] & (byte_nx[7:1] == TARGET_ADDR);
`endif
    end

    // Protocol state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            first_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_first_q <= 1'b0;
            stop_det_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
            first_q      <= first_d;
            pend_q       <= pend_d;
            pend_first_q <= pend_first_d;
            stop_det_q   <= stop_det_d;
        end
    end

    // Next state: START/STOP win over bit sampling; ACK drive only moves on SCL falls.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        oe_d         = oe_q;
        busy_d       = busy_q;
        first_d      = first_q;
        pend_d       = 1'b0;
        pend_first_d = 1'b0;
        stop_det_d   = 1'b0;
        if (stop_seen) begin
            state_d    = S_IDLE;
            oe_d       = 1'b0;
            busy_d     = 1'b0;
            bit_cnt_d  = 3'd0;
            first_d    = 1'b0;
            stop_det_d = 1'b1;
        end else if (start_det) begin
            state_d   = S_ADDR;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd0;
            first_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_nx;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            if (addr_ok) begin
                                state_d = S_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            state_d   = S_DATA;
                            bit_cnt_d = 3'd0;
                            if (state_q == S_ADDR_ACK) first_d = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_nx;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d    = 3'd0;
                            pend_d       = 1'b1;
                            pend_first_d = first_q;
                            first_d      = 1'b0;
                            state_d      = S_DATA_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_IGNORE: oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    // Deliver a completed byte one cycle after it was assembled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
        end else begin
            rx_valid_q <= pend_q;
            if (pend_q) begin
                rx_data_q  <= shift_q;
                rx_first_q <= pend_first_q;
            end
        end
    end

    // Reset releases the bus in the same cycle it is asserted.
    assign sda_oe   = oe_q & ~reset;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign busy     = busy_q;
    assign stop_det = stop_det_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bus-level I2C master stimulus against a transaction-level expectation model.
// Checks ACK slots, delivered bytes/first flags, busy, stop strobes, latency and reset behaviour.
// Directed scenarios followed by randomized transactions.
module tb_i2c_target_rx;

    localparam logic [6:0] TADDR = 7'h50;
    localparam int         SS    = 2;
    localparam int         Q     = 6;
`ifdef I2C_TARGET_GCALL_EN
    localparam bit GCALL = 1'b1;
`else
    localparam bit GCALL = 1'b0;
`endif

    typedef logic [7:0] bytes_t [$];
    typedef struct packed {
        logic       first;
        logic [7:0] dat;
    } rx_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, busy, stop_det;

    int  checks   = 0;
    int  failures = 0;
    rx_t got_q[$];
    rx_t exp_q[$];
    int  stop_cnt = 0;
    int  oe_viol  = 0;
    logic prev_oe = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx #(.TARGET_ADDR(TADDR), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .busy     (busy),
        .stop_det (stop_det)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe strobes and ACK-drive changes between clock edges.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (rx_valid) got_q.push_back({rx_first, rx_data});
            if (stop_det) stop_cnt++;
            if (sda_oe !== prev_oe && scl_m) oe_viol++;
        end
        prev_oe = sda_oe;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1; idle(Q);
            scl_m = 1'b1; idle(Q);
        end
        sda_m = 1'b0; idle(Q);
        scl_m = 1'b0; idle(Q);
    endtask

    task automatic do_stop();
        sda_m = 1'b0; idle(Q);
        scl_m = 1'b1; idle(Q);
        sda_m = 1'b1; idle(2*Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input bit lat_chk);
        int lat;
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i];
            idle(Q);
            scl_m = 1'b1;
            if (lat_chk && i == 0) begin
                lat = 0;
                for (int c = 1; c <= 2*Q; c++) begin
                    @(negedge clk);
                    if (rx_valid && lat == 0) lat = c;
                end
                chk("rx_latency", lat, SS + 2);
            end else begin
                idle(2*Q);
            end
            scl_m = 1'b0;
            idle(Q);
        end
    endtask

    task automatic ack_slot(input bit exp_ack, input string tag);
        sda_m = 1'b1;
        idle(Q);
        chk({tag, "_oe_low_phase"}, sda_oe, exp_ack);
        scl_m = 1'b1;
        idle(Q);
        chk({tag, "_line_high_phase"}, sda_line, !exp_ack);
        idle(Q);
        scl_m = 1'b0;
        idle(Q);
        chk({tag, "_released"}, sda_oe, 1'b0);
    endtask

    // One transaction: (repeated) START, address, data bytes, optional partial byte, optional STOP.
    task automatic xfer(input logic [6:0] a, input bit rw, input bytes_t dq,
                        input int part_n, input logic [7:0] part_v, input bit end_stop);
        bit  ack;
        int  s0;
        rx_t g, e;
        ack = !rw && (a == TADDR || (GCALL && a == 7'h00));
        do_start();
        send_bits({a, rw}, 8, 1'b0);
        ack_slot(ack, "addr_ack");
        chk("busy_after_addr", busy, ack);
        if (!rw) begin
            for (int i = 0; i < dq.size(); i++) begin
                send_bits(dq[i], 8, ack);
                ack_slot(ack, "data_ack");
                if (ack) exp_q.push_back({(i == 0), dq[i]});
            end
            if (part_n > 0) send_bits(part_v, part_n, 1'b0);
        end
        if (end_stop) begin
            s0 = stop_cnt;
            do_stop();
            chk("stop_det_pulses", stop_cnt - s0, 1);
            chk("busy_after_stop", busy, 1'b0);
        end
        chk("rx_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk("rx_first_data", g, e);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bytes_t dq;
        logic [6:0] ra;
        bit rw, es;
        int nb, pn;

        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        idle(3);
        chk("reset_sda_oe", sda_oe, 1'b0);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        reset = 1'b0;
        idle(4);

        // Write to our address, two bytes.
        dq = {}; dq.push_back(8'h12); dq.push_back(8'h34);
        xfer(7'h50, 1'b0, dq, 0, 8'h00, 1'b1);
        // Other address: never ACKed.
        dq = {}; dq.push_back(8'h55);
        xfer(7'h51, 1'b0, dq, 0, 8'h00, 1'b1);
        // Read request: NACK.
        dq = {};
        xfer(7'h50, 1'b1, dq, 0, 8'h00, 1'b1);
        // Partial byte dropped at repeated START.
        dq = {}; dq.push_back(8'h12);
        xfer(7'h50, 1'b0, dq, 4, 8'h3A, 1'b0);
        dq = {}; dq.push_back(8'h77);
        xfer(7'h50, 1'b0, dq, 0, 8'h00, 1'b1);

        // Reset during the address ACK slot.
        do_start();
        send_bits(8'hA0, 8, 1'b0);
        sda_m = 1'b1;
        idle(Q);
        chk("rst_pre_oe", sda_oe, 1'b1);
        scl_m = 1'b1;
        idle(2);
        reset = 1'b1;
        #1;
        chk("rst_oe_immediate", sda_oe, 1'b0);
        idle(2);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_first", rx_first, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stop_det", stop_det, 1'b0);
        reset = 1'b0;
        idle(Q);
        scl_m = 1'b0;
        idle(Q);
        got_q.delete();
        exp_q.delete();
        dq = {}; dq.push_back(8'h12); dq.push_back(8'h34);
        xfer(7'h50, 1'b0, dq, 0, 8'h00, 1'b1);

        // General call.
        dq = {}; dq.push_back(8'h06);
        xfer(7'h00, 1'b0, dq, 0, 8'h00, 1'b1);

        // Randomized transactions.
        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    ra = TADDR;
                2:       ra = 7'($urandom);
                default: ra = 7'h00;
            endcase
            rw = ($urandom_range(0, 4) == 0);
            nb = $urandom_range(0, 3);
            dq = {};
            for (int k = 0; k < nb; k++) dq.push_back(8'($urandom));
            pn = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            es = (t == 13) ? 1'b1 : ($urandom_range(0, 2) != 0);
            xfer(ra, rw, dq, pn, 8'($urandom), es);
        end

        chk("oe_change_while_scl_high", oe_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
